// File: rtl/scene_scheduler_pkg.sv
// Purpose: shared constants and types for the scene scheduler (config map, MODE bits, FSM encoding).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package scene_scheduler_pkg;

    // Config register addresses; 8-15 decode to nothing.
    localparam logic [3:0] ADDR_MAN_STATE  = 4'd0;
    localparam logic [3:0] ADDR_SOLID      = 4'd1;
    localparam logic [3:0] ADDR_AUDIO      = 4'd2;
    localparam logic [3:0] ADDR_MODE       = 4'd3;
    localparam logic [3:0] ADDR_PLAY_LEN   = 4'd4;
    localparam logic [3:0] ADDR_SLOT_PTR   = 4'd5;
    localparam logic [3:0] ADDR_SLOT_STATE = 4'd6;
    localparam logic [3:0] ADDR_SLOT_DUR   = 4'd7;

    // MODE register bit positions.
    localparam int MODE_AUTO_BIT = 0;
    localparam int MODE_LOOP_BIT = 1;

    // Background pattern shown out of reset and as the default manual state.
    localparam logic [7:0] BG_RESET = 8'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_t;

endpackage

// File: rtl/scene_slot_ram.sv
// Purpose: playlist slot table holding per-slot background state and duration in frames.
// Latency: writes land on the next clk edge; reads are combinational from rd_addr.
// Backpressure: none; every write strobe is accepted.
module scene_slot_ram #(
    parameter int NUM_SLOTS = 8,
    parameter int DUR_W     = 8,
    parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_state_en,
    input  logic             wr_dur_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_state,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_state,
    output logic [DUR_W-1:0] rd_dur
);

    logic [7:0]       state_mem [NUM_SLOTS];
    logic [DUR_W-1:0] dur_mem   [NUM_SLOTS];

    // Slot storage: cleared to state 0 / duration 1 on reset, then written directly by config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_mem[i] <= '0;
                dur_mem[i]   <= DUR_W'(1);
            end
        end else begin
            if (wr_state_en) state_mem[wr_addr] <= wr_state;
            if (wr_dur_en)   dur_mem[wr_addr]   <= wr_dur;
        end
    end

    assign rd_state = state_mem[rd_addr];
    assign rd_dur   = dur_mem[rd_addr];

endmodule

// File: rtl/scene_scheduler.sv
// Purpose: frame-synchronous scene scheduler; shadowed config committed at frame_start, slot playlist FSM.
// Latency: outputs change one clk after the frame_start cycle; slot table writes take effect next clk.
// Backpressure: none; config strobes and frame_start pulses are always accepted.
module scene_scheduler
    import scene_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int DUR_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_wr_en,
    input  logic [3:0]                   cfg_addr,
    input  logic [7:0]                   cfg_wdata,
    input  logic                         frame_start,
    output logic [7:0]                   background_state,
    output logic [5:0]                   solid_color,
    output logic                         audio_en,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
    output logic                         playing
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int LEN_W = IDX_W + 1;

    // Shadow registers written by config, consumed at commit.
    logic [7:0]       man_state_sh;
    logic [5:0]       solid_sh;
    logic             audio_sh;
    logic [1:0]       mode_sh;
    logic [LEN_W-1:0] play_len_sh;
    logic [IDX_W-1:0] slot_ptr;
    logic [LEN_W-1:0] play_len_wr;

    // Playlist state.
    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] cur_slot_q, cur_slot_d;
    logic [DUR_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]       bg_d;
    logic [5:0]       solid_d;
    logic             audio_d;
    logic [IDX_W-1:0] slot_idx_d;

    // Slot table interface.
    logic             ram_wr_state_en;
    logic             ram_wr_dur_en;
    logic [IDX_W-1:0] ram_rd_addr;
    logic [7:0]       ram_rd_state;
    logic [DUR_W-1:0] ram_rd_dur;
    logic [DUR_W-1:0] dur_last;
    logic [IDX_W:0]   next_slot;
    logic             mode_auto;
    logic             mode_loop;

    assign mode_auto = mode_sh[MODE_AUTO_BIT];
    assign mode_loop = mode_sh[MODE_LOOP_BIT];

    // Clamp PLAY_LEN writes into 1..NUM_SLOTS before they reach the shadow.
    always_comb begin
        play_len_wr = cfg_wdata[LEN_W-1:0];
        if (cfg_wdata == 8'd0) begin
            play_len_wr = LEN_W'(1);
        end else if (cfg_wdata > 8'(NUM_SLOTS)) begin
            play_len_wr = LEN_W'(NUM_SLOTS);
        end
    end

    // Config decode into shadows and the slot pointer; a duration write post-increments the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            man_state_sh <= BG_RESET;
            solid_sh     <= '0;
            audio_sh     <= 1'b0;
            mode_sh      <= '0;
            play_len_sh  <= LEN_W'(1);
            slot_ptr     <= '0;
        end else if (cfg_wr_en) begin
            case (cfg_addr)
                ADDR_MAN_STATE: man_state_sh <= cfg_wdata;
                ADDR_SOLID:     solid_sh     <= cfg_wdata[5:0];
                ADDR_AUDIO:     audio_sh     <= cfg_wdata[0];
                ADDR_MODE:      mode_sh      <= cfg_wdata[1:0];
                ADDR_PLAY_LEN:  play_len_sh  <= play_len_wr;
                ADDR_SLOT_PTR:  slot_ptr     <= cfg_wdata[IDX_W-1:0];
                ADDR_SLOT_DUR:  slot_ptr     <= slot_ptr + IDX_W'(1);
                default: ;
            endcase
        end
    end

    assign ram_wr_state_en = cfg_wr_en && (cfg_addr == ADDR_SLOT_STATE);
    assign ram_wr_dur_en   = cfg_wr_en && (cfg_addr == ADDR_SLOT_DUR);

    // IDLE only ever needs slot 0 (playlist entry); otherwise look at the current slot.
    assign ram_rd_addr = (state_q == ST_IDLE) ? '0 : cur_slot_q;

    scene_slot_ram #(
        .NUM_SLOTS (NUM_SLOTS),
        .DUR_W     (DUR_W),
        .IDX_W     (IDX_W)
    ) u_slot_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_state_en (ram_wr_state_en),
        .wr_dur_en   (ram_wr_dur_en),
        .wr_addr     (slot_ptr),
        .wr_state    (cfg_wdata),
        .wr_dur      (DUR_W'(cfg_wdata)),
        .rd_addr     (ram_rd_addr),
        .rd_state    (ram_rd_state),
        .rd_dur      (ram_rd_dur)
    );

    // A stored duration of 0 behaves as 1, so the last frame index is 0 in both cases.
    assign dur_last  = (ram_rd_dur == '0) ? '0 : ram_rd_dur - DUR_W'(1);
    assign next_slot = {1'b0, cur_slot_q} + (IDX_W + 1)'(1);

    // Next-state and output logic; everything moves only on a frame_start commit.
    always_comb begin
        state_d     = state_q;
        cur_slot_d  = cur_slot_q;
        frame_cnt_d = frame_cnt_q;
        bg_d        = background_state;
        solid_d     = solid_color;
        audio_d     = audio_en;
        slot_idx_d  = slot_idx;
        if (frame_start) begin
            solid_d = solid_sh;
            audio_d = audio_sh;
            case (state_q)
                ST_IDLE: begin
                    if (mode_auto) begin
                        state_d     = ST_PLAY;
                        cur_slot_d  = '0;
                        frame_cnt_d = '0;
                        bg_d        = ram_rd_state;
                        slot_idx_d  = '0;
                    end else begin
                        bg_d = man_state_sh;
                    end
                end
                ST_PLAY: begin
                    if (!mode_auto) begin
                        state_d     = ST_IDLE;
                        cur_slot_d  = '0;
                        frame_cnt_d = '0;
                        bg_d        = man_state_sh;
                        slot_idx_d  = '0;
                    end else begin
                        // Show the current slot this frame, then step the frame counter / slot.
                        bg_d       = ram_rd_state;
                        slot_idx_d = cur_slot_q;
                        if (frame_cnt_q >= dur_last) begin
                            frame_cnt_d = '0;
                            if (next_slot < play_len_sh) begin
                                cur_slot_d = next_slot[IDX_W-1:0];
                            end else if (mode_loop) begin
                                cur_slot_d = '0;
                            end else begin
                                state_d = ST_HOLD;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + DUR_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!mode_auto) begin
                        state_d     = ST_IDLE;
                        cur_slot_d  = '0;
                        frame_cnt_d = '0;
                        bg_d        = man_state_sh;
                        slot_idx_d  = '0;
                    end else begin
                        bg_d       = ram_rd_state;
                        slot_idx_d = cur_slot_q;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    cur_slot_d  = '0;
                    frame_cnt_d = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cur_slot_q       <= '0;
            frame_cnt_q      <= '0;
            background_state <= BG_RESET;
            solid_color      <= '0;
            audio_en         <= 1'b0;
            slot_idx         <= '0;
        end else begin
            state_q          <= state_d;
            cur_slot_q       <= cur_slot_d;
            frame_cnt_q      <= frame_cnt_d;
            background_state <= bg_d;
            solid_color      <= solid_d;
            audio_en         <= audio_d;
            slot_idx         <= slot_idx_d;
        end
    end

    assign playing = (state_q == ST_PLAY);

endmodule

// File: tb/tb_scene_scheduler.sv
// Purpose: self-checking bench for scene_scheduler using an expected-output scoreboard per frame commit.
// Latency: each frame_start is pulsed for one clk; outputs are compared at the following negedge.
// Backpressure: none; stimulus is driven on negedges with fixed cycle counts.
module tb_scene_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_wr_en = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       frame_start = 1'b0;
    logic [7:0] background_state;
    logic [5:0] solid_color;
    logic       audio_en;
    logic [2:0] slot_idx;
    logic       playing;

    typedef struct packed {
        logic [7:0] bg;
        logic [5:0] solid;
        logic       audio;
        logic [2:0] idx;
        logic       play;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Expected background / slot / playing sequences for the 3-slot playlist.
    logic [7:0] loop_bg  [8] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h01};
    logic [2:0] loop_idx [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd0};
    logic [7:0] hold_bg  [8] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03};
    logic [2:0] hold_idx [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
    logic       hold_ply [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    scene_scheduler #(
        .NUM_SLOTS (8),
        .DUR_W     (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .frame_start      (frame_start),
        .background_state (background_state),
        .solid_color      (solid_color),
        .audio_en         (audio_en),
        .slot_idx         (slot_idx),
        .playing          (playing)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] bg, input logic [5:0] solid, input logic audio,
                                input logic [2:0] idx, input logic play);
        exp_t e;
        e.bg = bg; e.solid = solid; e.audio = audio; e.idx = idx; e.play = play;
        return e;
    endfunction

    function automatic string show(input exp_t x);
        return $sformatf("bg=%h solid=%h audio=%b idx=%0d playing=%b", x.bg, x.solid, x.audio, x.idx, x.play);
    endfunction

    function automatic exp_t observed();
        return mk(background_state, solid_color, audio_en, slot_idx, playing);
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        cfg_wr_en = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    // One frame_start pulse, optionally with a coincident config write; queues the expected result.
    task automatic pulse_frame(input exp_t e, input logic wr, input logic [3:0] a, input logic [7:0] d);
        sb.push_back(e);
        frame_start = 1'b1;
        cfg_wr_en   = wr;
        cfg_addr    = a;
        cfg_wdata   = d;
        @(negedge clk);
        frame_start = 1'b0;
        cfg_wr_en   = 1'b0;
    endtask

    task automatic setup_playlist(input logic [7:0] mode);
        cfg_write(4'd5, 8'd0);
        cfg_write(4'd6, 8'h01); cfg_write(4'd7, 8'd2);
        cfg_write(4'd6, 8'h02); cfg_write(4'd7, 8'd1);
        cfg_write(4'd6, 8'h03); cfg_write(4'd7, 8'd3);
        cfg_write(4'd4, 8'd3);
        cfg_write(4'd3, mode);
    endtask

    task automatic test_reset();
        exp_t e, got;
        rst_n = 1'b0;
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== mk(8'd10, 6'd0, 1'b0, 3'd0, 1'b0)) begin
            failures++;
            $display("FAIL reset_hold: got %s, want bg=0a solid=00 audio=0 idx=0 playing=0", show(got));
        end
        rst_n = 1'b1;
        @(negedge clk);
        pulse_frame(mk(8'd10, 6'd0, 1'b0, 3'd0, 1'b0), 1'b0, 4'd0, 8'd0);
        e = sb.pop_front(); got = observed();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_first_frame: got %s, want %s", show(got), show(e));
        end
    endtask

    task automatic test_shadow();
        exp_t e, got;
        apply_reset();
        cfg_write(4'd0, 8'h22);
        cfg_write(4'd1, 8'h15);
        cfg_write(4'd2, 8'h01);
        repeat (2) @(negedge clk);
        got = observed();
        checks++;
        if (got !== mk(8'd10, 6'd0, 1'b0, 3'd0, 1'b0)) begin
            failures++;
            $display("FAIL shadow_no_commit: got %s, want bg=0a solid=00 audio=0 idx=0 playing=0", show(got));
        end
        pulse_frame(mk(8'h22, 6'h15, 1'b1, 3'd0, 1'b0), 1'b0, 4'd0, 8'd0);
        e = sb.pop_front(); got = observed();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL shadow_commit: got %s, want %s", show(got), show(e));
        end
    endtask

    task automatic test_playlist_loop();
        exp_t e, got;
        apply_reset();
        setup_playlist(8'd3);
        for (int i = 0; i < 8; i++) begin
            pulse_frame(mk(loop_bg[i], 6'd0, 1'b0, loop_idx[i], 1'b1), 1'b0, 4'd0, 8'd0);
            e = sb.pop_front(); got = observed();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL loop_step%0d: got %s, want %s", i, show(got), show(e));
            end
        end
    endtask

    task automatic test_playlist_hold();
        exp_t e, got;
        apply_reset();
        setup_playlist(8'd1);
        cfg_write(4'd0, 8'h66);
        for (int i = 0; i < 8; i++) begin
            pulse_frame(mk(hold_bg[i], 6'd0, 1'b0, hold_idx[i], hold_ply[i]), 1'b0, 4'd0, 8'd0);
            e = sb.pop_front(); got = observed();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL hold_step%0d: got %s, want %s", i, show(got), show(e));
            end
        end
        cfg_write(4'd3, 8'd0);
        pulse_frame(mk(8'h66, 6'd0, 1'b0, 3'd0, 1'b0), 1'b0, 4'd0, 8'd0);
        e = sb.pop_front(); got = observed();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL hold_to_idle: got %s, want %s", show(got), show(e));
        end
    endtask

    task automatic test_coincident_write();
        exp_t e, got;
        apply_reset();
        pulse_frame(mk(8'd10, 6'd0, 1'b0, 3'd0, 1'b0), 1'b1, 4'd0, 8'h44);
        e = sb.pop_front(); got = observed();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL coincident_old: got %s, want %s", show(got), show(e));
        end
        pulse_frame(mk(8'h44, 6'd0, 1'b0, 3'd0, 1'b0), 1'b0, 4'd0, 8'd0);
        e = sb.pop_front(); got = observed();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL coincident_new: got %s, want %s", show(got), show(e));
        end
    endtask

    task automatic test_edge_cases();
        exp_t e, got;
        exp_t want [5];
        // PLAY_LEN=0 behaves as 1; no loop -> one slot then HOLD.
        apply_reset();
        cfg_write(4'd6, 8'h51); cfg_write(4'd7, 8'd0);
        cfg_write(4'd6, 8'h52); cfg_write(4'd7, 8'd0);
        cfg_write(4'd4, 8'd0);
        cfg_write(4'd3, 8'd1);
        want[0] = mk(8'h51, 6'd0, 1'b0, 3'd0, 1'b1);
        want[1] = mk(8'h51, 6'd0, 1'b0, 3'd0, 1'b0);
        want[2] = mk(8'h51, 6'd0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse_frame(want[i], 1'b0, 4'd0, 8'd0);
            e = sb.pop_front(); got = observed();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL len0_step%0d: got %s, want %s", i, show(got), show(e));
            end
        end
        // Duration 0 advances every frame; two slots looping.
        apply_reset();
        cfg_write(4'd6, 8'h51); cfg_write(4'd7, 8'd0);
        cfg_write(4'd6, 8'h52); cfg_write(4'd7, 8'd0);
        cfg_write(4'd4, 8'd2);
        cfg_write(4'd3, 8'd3);
        want[0] = mk(8'h51, 6'd0, 1'b0, 3'd0, 1'b1);
        want[1] = mk(8'h51, 6'd0, 1'b0, 3'd0, 1'b1);
        want[2] = mk(8'h52, 6'd0, 1'b0, 3'd1, 1'b1);
        want[3] = mk(8'h51, 6'd0, 1'b0, 3'd0, 1'b1);
        want[4] = mk(8'h52, 6'd0, 1'b0, 3'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            pulse_frame(want[i], 1'b0, 4'd0, 8'd0);
            e = sb.pop_front(); got = observed();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL dur0_step%0d: got %s, want %s", i, show(got), show(e));
            end
        end
        // Reset asserted mid-PLAY, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== mk(8'd10, 6'd0, 1'b0, 3'd0, 1'b0)) begin
            failures++;
            $display("FAIL async_reset: got %s, want bg=0a solid=00 audio=0 idx=0 playing=0", show(got));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Writes to unmapped addresses leave everything untouched.
        cfg_write(4'd9, 8'h77);
        cfg_write(4'd8, 8'h55);
        cfg_write(4'd12, 8'h03);
        pulse_frame(mk(8'd10, 6'd0, 1'b0, 3'd0, 1'b0), 1'b0, 4'd0, 8'd0);
        e = sb.pop_front(); got = observed();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL unmapped_addr: got %s, want %s", show(got), show(e));
        end
    endtask

    initial begin
        test_reset();
        test_shadow();
        test_playlist_loop();
        test_playlist_hold();
        test_coincident_write();
        test_edge_cases();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scene_scheduler.md
SCENE_SCHEDULER -- requirements
Module: scene_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 8, meaning number of playlist slots (power of two, at most 16).
REQ-002 Parameter DUR_W, default 8, meaning width of the per-slot duration in frames.
REQ-003 clk  in  1  system clock; one clock domain; all state is updated on the rising edge of clk.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 cfg_wr_en  in  1  one-cycle write strobe from the SPI config decoder, already synchronised to clk.
REQ-006 cfg_addr  in  4  config register address.
REQ-007 cfg_wdata  in  8  config write data.
REQ-008 frame_start  in  1  one-cycle pulse at the start of vertical blanking.
REQ-009 background_state  out  8  active background pattern select, registered.
REQ-010 solid_color  out  6  active solid colour, registered.
REQ-011 audio_en  out  1  active audio enable, registered.
REQ-012 slot_idx  out  log2(NUM_SLOTS)  playlist slot currently shown.
REQ-013 playing  out  1  high while state is PLAY.

Function
REQ-014 Config map: 0 MAN_STATE[7:0]; 1 SOLID[5:0]; 2 AUDIO[0]; 3 MODE (bit0 auto, bit1 loop); 4 PLAY_LEN; 5 SLOT_PTR; 6 SLOT_STATE; 7 SLOT_DUR; addresses 8-15 are ignored with no side effect.
REQ-015 Writes to addresses 0-4 SHALL update shadow registers only; the outputs SHALL change only at a commit, which occurs on a cycle with frame_start high.
REQ-016 Outputs SHALL update one cycle after the frame_start cycle.
REQ-017 A cfg write coincident with frame_start SHALL reach its shadow register, but that commit SHALL use the pre-write shadow value.
REQ-018 PLAY_LEN SHALL be clamped to the range 1..NUM_SLOTS; a written value of 0 SHALL be stored as 1.
REQ-019 A write to address 6 SHALL set the state of slot SLOT_PTR; a write to address 7 SHALL set its duration and then advance SLOT_PTR by 1, modulo NUM_SLOTS.
REQ-020 Slot tables SHALL be written immediately, not shadowed; a stored duration of 0 SHALL behave as 1.
REQ-021 The FSM SHALL have the states IDLE, PLAY and HOLD.
REQ-022 IDLE: at each commit, background_state SHALL take MAN_STATE; if MODE.auto is set, the FSM SHALL go to PLAY with slot_idx=0 and frame_cnt=0, and SHALL output slot 0's state.
REQ-023 PLAY: at each commit, if frame_cnt equals the effective duration minus 1, then frame_cnt SHALL go to 0 and the slot SHALL advance; otherwise frame_cnt SHALL increment by 1.
REQ-024 PLAY advance: if the next slot is below PLAY_LEN, the FSM SHALL move to it; otherwise, with loop set it SHALL wrap to slot 0, and with loop clear it SHALL go to HOLD on the last slot.
REQ-025 HOLD: the last slot's state SHALL be held.
REQ-026 PLAY or HOLD: when MODE.auto is clear at a commit, the FSM SHALL go to IDLE and output MAN_STATE at that same commit.
REQ-027 solid_color and audio_en SHALL commit from shadow in every FSM state.
REQ-028 If PLAY_LEN is shrunk below slot_idx+1 during PLAY, the next advance SHALL apply the wrap or HOLD rule of REQ-024.
REQ-029 frame_cnt SHALL be DUR_W bits wide and SHALL never exceed the effective duration minus 1.

Reset
REQ-030 While rst_n is low: background_state=10, solid_color=0, audio_en=0, slot_idx=0, playing=0, FSM=IDLE, frame_cnt=0, SLOT_PTR=0.
REQ-031 While rst_n is low, the shadow registers SHALL take: MAN_STATE=10, SOLID=0, AUDIO=0, MODE=0, PLAY_LEN=1.
REQ-032 While rst_n is low, every slot SHALL take state=0 and duration=1.
REQ-033 Reset asserted mid-playback SHALL force these values immediately, independent of clk.

Structure
REQ-034 A shared package SHALL hold the config address constants (0-7), the MODE bit positions, the reset background value 10 and the FSM state encoding.
REQ-035 The slot table SHALL be one sub-module, scene_slot_ram: one write port, one asynchronous read port, with reset.

Verification
REQ-036 Reset release, then frame_start -> background_state=10, solid_color=0, audio_en=0, playing=0.
REQ-037 Write addr0=0x22 and addr1=0x15 with no frame_start -> outputs unchanged; after frame_start -> background_state=0x22, solid_color=0x15.
REQ-038 Slots {0x01 dur 2, 0x02 dur 1, 0x03 dur 3}, PLAY_LEN=3, MODE=3 -> across successive frame_starts background_state reads 01,01,01,02,03,03,03,01 (wrap).
REQ-039 Same playlist with MODE=1 -> the sequence ends holding 0x03 in HOLD; then MODE=0 -> next frame_start outputs MAN_STATE and playing=0.
REQ-040 Write addr0=0x44 in the same cycle as frame_start -> that commit keeps the old value; the next frame_start outputs 0x44.
REQ-041 Edge cases: PLAY_LEN=0 -> acts as 1; duration 0 -> advances every frame; write to addr 9 -> no change; rst_n asserted mid-PLAY -> reset values immediately.
